// File: rtl/seg_updown_counter_display.sv
// BCD up/down counter with run-control FSM, count-tick divider and multiplexed
// seven-segment scan for DIGITS digits.
module seg_updown_counter_display #(
    parameter int DIGITS         = 4,
    parameter int CLK_HZ         = 100000000,
    parameter int COUNT_HZ       = 1,
    parameter int SCAN_HZ        = 1000,
    parameter bit BLANK_LZ       = 1'b0,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                clk_100MHz,
    input  logic                reset_n,
    input  logic                start,
    input  logic                progressive,
    input  logic                regressive,
    input  logic                hold,
    input  logic [4*DIGITS-1:0] target,
    output logic [4*DIGITS-1:0] count_bcd,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   an,
    output logic                running,
    output logic                finish
);
    localparam int CNT_W     = 4 * DIGITS;
    localparam int TICK_TERM = CLK_HZ / COUNT_HZ - 1;
    localparam int SCAN_TERM = CLK_HZ / SCAN_HZ - 1;
    localparam int TICK_W    = (TICK_TERM < 1) ? 1 : $clog2(TICK_TERM + 1);
    localparam int SCAN_W    = (SCAN_TERM < 1) ? 1 : $clog2(SCAN_TERM + 1);
    localparam int IDX_W     = (DIGITS < 2) ? 1 : $clog2(DIGITS);

    localparam logic [6:0]        SEG_XOR = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_XOR  = {DIGITS{AN_ACTIVE_LOW}};

    typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DOWN, DONE} state_t;

    function automatic logic [CNT_W-1:0] clamp_bcd(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] bcd_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        logic             carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] bcd_dec(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        logic             borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Active-high {g,f,e,d,c,b,a}; polarity is applied at the output register.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    state_t            state, state_next;
    logic [CNT_W-1:0]  lim;
    logic [CNT_W-1:0]  count_step;
    logic [TICK_W-1:0] tick_div;
    logic              valid_start;
    logic              counting;
    logic              tick;

    assign valid_start = start & (progressive ^ regressive);
    assign counting    = (state == RUN_UP) || (state == RUN_DOWN);
    assign tick        = counting && !hold && (tick_div == TICK_W'(TICK_TERM));
    assign count_step  = (state == RUN_UP) ? bcd_inc(count_bcd) : bcd_dec(count_bcd);

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // A valid start overrides everything, including a tick landing on the same edge.
    always_comb begin
        state_next = state;
        case (state)
            RUN_UP, RUN_DOWN: begin
                if (count_bcd == lim)
                    state_next = DONE;
                else if (tick && (count_step == lim))
                    state_next = DONE;
            end
            default: state_next = state;
        endcase
        if (valid_start)
            state_next = progressive ? RUN_UP : RUN_DOWN;
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            count_bcd <= '0;
            lim       <= '0;
            tick_div  <= '0;
            running   <= 1'b0;
            finish    <= 1'b0;
        end else begin
            running <= (state_next == RUN_UP) || (state_next == RUN_DOWN);
            finish  <= (state_next == DONE);
            if (valid_start) begin
                tick_div <= '0;
                if (progressive) begin
                    count_bcd <= '0;
                    lim       <= clamp_bcd(target);
                end else begin
                    count_bcd <= clamp_bcd(target);
                    lim       <= '0;
                end
            end else if (counting && !hold) begin
                if (tick) begin
                    tick_div <= '0;
                    if (count_bcd != lim) count_bcd <= count_step;
                end else begin
                    tick_div <= tick_div + TICK_W'(1);
                end
            end
        end
    end

    logic [SCAN_W-1:0] scan_div;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        cur_digit;
    logic [DIGITS-1:0] an_onehot;
    logic [DIGITS-1:0] blank_mask;
    logic              lz_run;
    logic              blank_sel;
    logic [6:0]        seg_raw;
    logic [6:0]        seg_p1;
    logic [DIGITS-1:0] an_p1;
    logic              dp_p1;

    always_comb begin
        cur_digit = 4'd0;
        an_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit    = count_bcd[4*i +: 4];
                an_onehot[i] = 1'b1;
            end
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        blank_mask = '0;
        lz_run     = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lz_run        = lz_run & (count_bcd[4*i +: 4] == 4'd0);
            blank_mask[i] = lz_run;
        end
    end

    assign blank_sel = BLANK_LZ && (|(blank_mask & an_onehot));
    assign seg_raw   = blank_sel ? 7'h00 : seg_decode(cur_digit);

    // Scan output stage: one register between index/digit select and the pins.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            scan_div <= '0;
            idx      <= '0;
            seg_p1   <= SEG_XOR;
            an_p1    <= AN_XOR;
            dp_p1    <= SEG_ACTIVE_LOW;
        end else begin
            seg_p1 <= seg_raw ^ SEG_XOR;
            an_p1  <= an_onehot ^ AN_XOR;
            dp_p1  <= ((idx == '0) && running && hold) ^ SEG_ACTIVE_LOW;
            if (scan_div == SCAN_W'(SCAN_TERM)) begin
                scan_div <= '0;
                idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                scan_div <= scan_div + SCAN_W'(1);
            end
        end
    end

    assign seg = seg_p1;
    assign an  = an_p1;
    assign dp  = dp_p1;

endmodule
